// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : des_pkg
//  Purpose   : Shared widths, pair-FSM state encoding and the byte-swap helper
//              used by the DES block packer.
//  Revision  : 1.0  initial release
// ============================================================================
package des_pkg;

  localparam int DES_WORD_W = 32;
  localparam int DES_BLK_W  = 64;

  // Pair FSM: either no word held, or a low half waiting for its partner
  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_HALF  = 1'b1
  } pair_state_e;

  // Reverse the byte order of one 32-bit word
  function automatic logic [DES_WORD_W-1:0] byte_swap(input logic [DES_WORD_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/des_blk_fifo.sv
`default_nettype none
// ============================================================================
//  Module    : des_blk_fifo
//  Purpose   : DEPTH x 64-bit synchronous FIFO with a register-backed head and
//              a level output. Push/pop arrive already qualified by the caller
//              (no full/empty protection inside).
//  Revision  : 1.0  initial release
// ============================================================================
module des_blk_fifo
  import des_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clear,
  input  logic                 i_push,
  input  logic [DES_BLK_W-1:0] i_push_data,
  input  logic                 i_pop,
  output logic [DES_BLK_W-1:0] o_head,
  output logic [LVL_W-1:0]     o_level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DES_BLK_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]     r_level;

  // Storage array: written only on an accepted push
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Head reads zero when empty so reset/clear leave a clean output
  assign o_head  = (r_level != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/des_block_packer.sv
`default_nettype none
// ============================================================================
//  Module    : des_block_packer
//  Purpose   : Pairs the 32-bit PipeIn word stream into 64-bit DES blocks,
//              queues them in des_blk_fifo and hands them out over valid/ready.
//              Flush pads a dangling half block with PAD_WORD.
//  Config    : DES_PACK_BYTESWAP_EN -- byte-reverse each incoming word before
//              packing (PAD_WORD is never swapped).
//  Revision  : 1.0  initial release
// ============================================================================
module des_block_packer
  import des_pkg::*;
#(
  parameter int                    DEPTH    = 8,
  parameter logic [DES_WORD_W-1:0] PAD_WORD = 32'h0,
  parameter int                    CNT_W    = 16
) (
  input  logic                    okClk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    word_valid,
  input  logic [DES_WORD_W-1:0]   word_data,
  input  logic                    flush,
  output logic                    blk_valid,
  output logic [DES_BLK_W-1:0]    blk_data,
  input  logic                    blk_ready,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    half_pending,
  output logic                    overflow,
  output logic [CNT_W-1:0]        blk_count
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  pair_state_e          r_state;
  pair_state_e          w_state_nxt;
  logic [DES_WORD_W-1:0] r_low;
  logic                 r_overflow;
  logic [CNT_W-1:0]     r_count;

  logic [DES_WORD_W-1:0] w_word;
  logic                  w_latch;
  logic                  w_push_req;
  logic [DES_BLK_W-1:0]  w_push_data;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_push_ok;
  logic                  w_drop;
  logic [LVL_W-1:0]      w_level;

`ifdef DES_PACK_BYTESWAP_EN
  assign w_word = byte_swap(word_data);
`else
  assign w_word = word_data;
`endif

  assign blk_valid = (w_level != '0);
  assign w_pop     = blk_valid && blk_ready && !clear;
  assign w_full    = (w_level == LVL_W'(DEPTH));
  // A full FIFO can still take a block when the head leaves the same cycle
  assign w_push_ok = w_push_req && (!w_full || w_pop);
  assign w_drop    = w_push_req && !w_push_ok;

  // Pair FSM next state and block assembly
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_push_req  = 1'b0;
    w_push_data = '0;
    case (r_state)
      S_EMPTY: begin
        if (word_valid && flush) begin
          w_push_req  = 1'b1;
          w_push_data = {PAD_WORD, w_word};
        end else if (word_valid) begin
          w_latch     = 1'b1;
          w_state_nxt = S_HALF;
        end
      end
      S_HALF: begin
        if (word_valid) begin
          w_push_req  = 1'b1;
          w_push_data = {w_word, r_low};
          w_state_nxt = S_EMPTY;
        end else if (flush) begin
          w_push_req  = 1'b1;
          w_push_data = {PAD_WORD, r_low};
          w_state_nxt = S_EMPTY;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    if (clear) begin
      w_state_nxt = S_EMPTY;
      w_latch     = 1'b0;
      w_push_req  = 1'b0;
    end
  end

  // State, held low word, sticky overflow and handed-off block counter
  always_ff @(posedge okClk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_EMPTY;
      r_low      <= '0;
      r_overflow <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) r_low <= w_word;
      if (clear) begin
        r_overflow <= 1'b0;
        r_count    <= '0;
      end else begin
        if (w_drop) r_overflow <= 1'b1;
        if (w_pop)  r_count    <= r_count + CNT_W'(1);
      end
    end
  end

  des_blk_fifo #(
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk         (okClk),
    .rst_n       (reset_n),
    .i_clear     (clear),
    .i_push      (w_push_ok),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (blk_data),
    .o_level     (w_level)
  );

  assign fifo_level   = w_level;
  assign half_pending = (r_state == S_HALF);
  assign overflow     = r_overflow;
  assign blk_count    = r_count;

endmodule
`default_nettype wire
